// File: rtl/urp_pcie_pkg.sv
// Shared widths, beat count and serializer FSM state type for the PCIe CRC32 frame serializer.
package urp_pcie_pkg;

  localparam int unsigned DataWidth = 224;
  localparam int unsigned CrcWidth  = 32;
  localparam int unsigned OutWidth  = 64;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned FrameWidth = DataWidth + CrcWidth;
  localparam int unsigned NumBeats   = FrameWidth / OutWidth;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } ser_state_e;

  // Width of a counter that indexes 0..beats-1; never narrower than one bit.
  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/urp_pcie_crc32_ser_if.sv
// Frame-in / beat-out bus of the CRC32 serializer; slave is the serializer, master drives it.
interface urp_pcie_crc32_ser_if
  import urp_pcie_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned CRC_WIDTH  = CrcWidth,
  parameter int unsigned OUT_WIDTH  = OutWidth
);

  logic                  valid_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [CRC_WIDTH-1:0]  checksum_i;
  logic                  ready_i;
  logic                  valid_o;
  logic [OUT_WIDTH-1:0]  data_o;
  logic                  last_o;
  logic                  overflow_o;

  modport master (
    output valid_i,
    output data_i,
    output checksum_i,
    output ready_i,
    input  valid_o,
    input  data_o,
    input  last_o,
    input  overflow_o
  );

  modport slave (
    input  valid_i,
    input  data_i,
    input  checksum_i,
    input  ready_i,
    output valid_o,
    output data_o,
    output last_o,
    output overflow_o
  );

endinterface

// File: rtl/urp_pcie_frame_fifo.sv
// Synchronous frame FIFO; a push while full is taken only when a pop happens on the same edge.
module urp_pcie_frame_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AddrW = $clog2(DEPTH),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CntW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == CntW'(DEPTH));

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + CntW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/urp_pcie_crc32_ser.sv
// Buffers {checksum, payload} frames and emits them LSB-first as OUT_WIDTH beats with last_o.
// Define URP_PCIE_SER_STATS_EN to add frame_cnt_o / drop_cnt_o statistics outputs.
module urp_pcie_crc32_ser
  import urp_pcie_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned CRC_WIDTH  = CrcWidth,
  parameter int unsigned OUT_WIDTH  = OutWidth,
  parameter int unsigned FIFO_DEPTH = FifoDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  urp_pcie_crc32_ser_if.slave        bus
`ifdef URP_PCIE_SER_STATS_EN
  ,
  output logic [31:0]                frame_cnt_o,
  output logic [15:0]                drop_cnt_o
`endif
);

  localparam int unsigned FrmW     = DATA_WIDTH + CRC_WIDTH;
  localparam int unsigned Beats    = FrmW / OUT_WIDTH;
  localparam int unsigned BeatCntW = beat_cnt_width(Beats);
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;

  ser_state_e            state_q, state_d;
  logic [BeatCntW-1:0]   beat_q, beat_d;
  logic                  armed_q;
  logic                  overflow_q;

  logic [FrmW-1:0]       frame_in;
  logic [FrmW-1:0]       fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CntW-1:0]       fifo_count;

  logic [Beats-1:0][OUT_WIDTH-1:0] head_beats;

  logic                  sending;
  logic                  last_beat;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign frame_in   = {bus.checksum_i, bus.data_i};
  assign head_beats = fifo_head;

  assign sending   = (state_q == StSend);
  assign last_beat = (beat_q == BeatCntW'(Beats - 1));
  assign accept    = sending && bus.ready_i;
  assign pop       = accept && last_beat;

  // armed_q blocks the first edge after reset release; no frame is taken or dropped there.
  assign push = armed_q && bus.valid_i && (!fifo_full || pop);
  assign drop = armed_q && bus.valid_i && fifo_full && !pop;

  urp_pcie_frame_fifo #(
    .WIDTH (FrmW),
    .DEPTH (FIFO_DEPTH)
  ) u_frame_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (frame_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          if (last_beat) begin
            beat_d = '0;
            // Stay in SEND for a back-to-back frame; the head popped now was the only entry.
            if ((fifo_count == CntW'(1)) && !push) begin
              state_d = StIdle;
            end
          end else begin
            beat_d = beat_q + BeatCntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      armed_q <= 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.valid_o    = sending;
  assign bus.last_o     = sending && last_beat;
  assign bus.data_o     = sending ? head_beats[beat_q] : '0;
  assign bus.overflow_o = overflow_q;

`ifdef URP_PCIE_SER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (pop) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_urp_pcie_crc32_ser.sv
// Directed self-checking bench for urp_pcie_crc32_ser; inputs driven and outputs sampled on negedge.
module tb_urp_pcie_crc32_ser;
  import urp_pcie_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  urp_pcie_crc32_ser_if bus ();

`ifdef URP_PCIE_SER_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  urp_pcie_crc32_ser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef URP_PCIE_SER_STATS_EN
    ,
    .frame_cnt_o (frame_cnt),
    .drop_cnt_o  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [223:0] mk_data(input logic [7:0] tag);
    logic [223:0] d;
    for (int j = 0; j < 7; j++) d[j*32 +: 32] = {tag, 8'(j), 16'h5A5A};
    return d;
  endfunction

  function automatic logic [31:0] mk_crc(input logic [7:0] tag);
    return {24'hC0DE00, tag};
  endfunction

  function automatic logic [63:0] beat_of(input logic [223:0] d, input logic [31:0] c,
                                          input int k);
    logic [255:0] f;
    f = {c, d};
    return f[k*64 +: 64];
  endfunction

  task automatic drive(input logic [7:0] tag);
    bus.valid_i    = 1'b1;
    bus.data_i     = mk_data(tag);
    bus.checksum_i = mk_crc(tag);
  endtask

  task automatic idle_in();
    bus.valid_i = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] ftag, input int k);
    chk($sformatf("%s_b%0d_valid", tag, k), 64'(bus.valid_o), 64'd1);
    chk($sformatf("%s_b%0d_data", tag, k), bus.data_o, beat_of(mk_data(ftag), mk_crc(ftag), k));
    chk($sformatf("%s_b%0d_last", tag, k), 64'(bus.last_o), (k == 3) ? 64'd1 : 64'd0);
  endtask

  // Expects beat 0 of the frame visible and ready_i high; ends after beat 3 is accepted.
  task automatic drain(input string tag, input logic [7:0] ftag);
    for (int k = 0; k < 4; k++) begin
      check_beat(tag, ftag, k);
      step();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.data_i     = '0;
    bus.checksum_i = '0;
    bus.ready_i    = 1'b1;

    #2;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_last", 64'(bus.last_o), 64'd0);
    chk("rst_data", bus.data_o, 64'd0);
    chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
    step();
    step();

    // Frame offered on the first edge after release must be ignored.
    rst = 1'b0;
    drive(8'hEE);
    step();
    idle_in();
    step();
    chk("first_edge_ignored", 64'(bus.valid_o), 64'd0);

    // Single frame, hand-computed beats.
    bus.valid_i    = 1'b1;
    bus.data_i     = 224'h77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    bus.checksum_i = 32'hDEADBEEF;
    step();
    idle_in();
    chk("lat_not_yet", 64'(bus.valid_o), 64'd0);
    step();
    chk("a_b0_valid", 64'(bus.valid_o), 64'd1);
    chk("a_b0_data", bus.data_o, 64'h22222222_11111111);
    chk("a_b0_last", 64'(bus.last_o), 64'd0);
    step();
    chk("a_b1_data", bus.data_o, 64'h44444444_33333333);
    chk("a_b1_last", 64'(bus.last_o), 64'd0);
    step();
    chk("a_b2_data", bus.data_o, 64'h66666666_55555555);
    chk("a_b2_last", 64'(bus.last_o), 64'd0);
    step();
    chk("a_b3_valid", 64'(bus.valid_o), 64'd1);
    chk("a_b3_data", bus.data_o, 64'hDEADBEEF_77777777);
    chk("a_b3_last", 64'(bus.last_o), 64'd1);
    step();
    chk("a_done_valid", 64'(bus.valid_o), 64'd0);

    // Back-to-back frames: eight beats, no bubble.
    drive(8'hB0);
    step();
    drive(8'hC0);
    step();
    idle_in();
    drain("b", 8'hB0);
    drain("c", 8'hC0);
    chk("bc_done_valid", 64'(bus.valid_o), 64'd0);

    // Backpressure on beat 1 for five cycles.
    drive(8'hD0);
    step();
    idle_in();
    step();
    check_beat("d", 8'hD0, 0);
    step();
    check_beat("d", 8'hD0, 1);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_beat($sformatf("d_hold%0d", i), 8'hD0, 1);
    end
    bus.ready_i = 1'b1;
    step();
    check_beat("d", 8'hD0, 2);
    step();
    check_beat("d", 8'hD0, 3);
    step();
    chk("d_done_valid", 64'(bus.valid_o), 64'd0);

    // FIFO full while the last beat is accepted: incoming frame is taken, no overflow.
    bus.ready_i = 1'b0;
    drive(8'hF1);
    step();
    drive(8'hF2);
    step();
    drive(8'hF3);
    step();
    drive(8'hF4);
    step();
    idle_in();
    chk("full_ovf", 64'(bus.overflow_o), 64'd0);
    check_beat("f1", 8'hF1, 0);
    bus.ready_i = 1'b1;
    step();
    check_beat("f1", 8'hF1, 1);
    step();
    check_beat("f1", 8'hF1, 2);
    step();
    check_beat("f1", 8'hF1, 3);
    drive(8'hF5);
    step();
    idle_in();
    chk("coincide_ovf", 64'(bus.overflow_o), 64'd0);
    drain("f2", 8'hF2);
    drain("f3", 8'hF3);
    drain("f4", 8'hF4);
    drain("f5", 8'hF5);
    chk("f_done_valid", 64'(bus.valid_o), 64'd0);
    chk("f_done_ovf", 64'(bus.overflow_o), 64'd0);

    // Six frames into a stalled depth-4 FIFO: frames 5 and 6 dropped.
    bus.ready_i = 1'b0;
    drive(8'hE1);
    step();
    drive(8'hE2);
    step();
    drive(8'hE3);
    step();
    drive(8'hE4);
    step();
    chk("pre_drop_ovf", 64'(bus.overflow_o), 64'd0);
    drive(8'hE5);
    step();
    chk("drop5_ovf", 64'(bus.overflow_o), 64'd1);
    drive(8'hE6);
    step();
    idle_in();
    chk("drop6_ovf", 64'(bus.overflow_o), 64'd1);
    check_beat("e1_stall", 8'hE1, 0);
    bus.ready_i = 1'b1;
    drain("e1", 8'hE1);
    drain("e2", 8'hE2);
    drain("e3", 8'hE3);
    drain("e4", 8'hE4);
    chk("e_no_dropped_out", 64'(bus.valid_o), 64'd0);
    chk("ovf_sticky", 64'(bus.overflow_o), 64'd1);
`ifdef URP_PCIE_SER_STATS_EN
    chk("stat_frames", 64'(frame_cnt), 64'd13);
    chk("stat_drops", 64'(drop_cnt), 64'd2);
`endif

    // Reset asserted asynchronously during beat 2.
    drive(8'h60);
    step();
    idle_in();
    step();
    step();
    step();
    check_beat("g", 8'h60, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
    chk("mid_rst_data", bus.data_o, 64'd0);
    chk("mid_rst_last", 64'(bus.last_o), 64'd0);
    chk("mid_rst_ovf", 64'(bus.overflow_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("no_resume", 64'(bus.valid_o), 64'd0);
    drive(8'h70);
    step();
    idle_in();
    step();
    drain("h", 8'h70);
    chk("h_done_valid", 64'(bus.valid_o), 64'd0);
`ifdef URP_PCIE_SER_STATS_EN
    chk("stat_frames_rst", 64'(frame_cnt), 64'd1);
    chk("stat_drops_rst", 64'(drop_cnt), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/urp_pcie_crc32_ser.md
URP_PCIE_CRC32_SER -- requirements
Module: urp_pcie_crc32_ser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 224, payload bits per frame.
REQ-002 SHALL have parameter CRC_WIDTH, default 32, checksum bits per frame.
REQ-003 SHALL have parameter OUT_WIDTH, default 64, output beat width; (DATA_WIDTH+CRC_WIDTH)/OUT_WIDTH SHALL be an integer (4 by default).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, frame buffer entries, power of two, at least 2.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 valid_i  input  1  frame present from CRC encoder stage; no backpressure upstream.
REQ-008 data_i  input  DATA_WIDTH  frame payload.
REQ-009 checksum_i  input  CRC_WIDTH  CRC32 of data_i, same cycle as valid_i.
REQ-010 valid_o  output  1  beat valid.
REQ-011 ready_i  input  1  downstream accepts beat when valid_o and ready_i are both high.
REQ-012 data_o  output  OUT_WIDTH  beat payload.
REQ-013 last_o  output  1  high on final beat of a frame.
REQ-014 overflow_o  output  1  sticky: a frame was dropped.

Function
REQ-015 SHALL push {checksum_i, data_i} into the frame FIFO on the edge where valid_i is high and FIFO is not full, or full with a pop in the same cycle.
REQ-016 SHALL drop the frame and set overflow_o when valid_i is high, FIFO is full and no pop occurs that cycle; FIFO contents SHALL be unchanged.
REQ-017 SHALL serialize each frame LSB-first: beat0 data[63:0], beat1 data[127:64], beat2 data[191:128], beat3 {checksum, data[223:192]}.
REQ-018 SHALL use FSM IDLE/SEND; IDLE->SEND when FIFO non-empty; SEND->IDLE after the last beat is accepted and FIFO is empty; SEND->SEND (beat 0 of next frame, no bubble) after the last beat is accepted and FIFO is non-empty.
REQ-019 SHALL assert valid_o whenever in SEND; beat counter SHALL advance only on valid_o and ready_i, wrapping from 3 to 0.
REQ-020 SHALL hold data_o, last_o and valid_o stable while valid_o is high and ready_i is low.
REQ-021 SHALL pop the FIFO head when the beat with last_o high is accepted.
REQ-022 Minimum latency: valid_i at edge N into an empty FIFO SHALL give valid_o high with beat0 after edge N+1.
REQ-023 overflow_o SHALL stay high until reset.

Reset
REQ-024 On rst high, independent of clk: valid_o=0, last_o=0, data_o=0, overflow_o=0, FSM=IDLE, beat counter=0, FIFO empty.
REQ-025 Reset mid-frame SHALL discard the partial frame and all buffered frames; no resumption after reset.
REQ-026 Deassertion of rst SHALL be synchronised externally; no frame SHALL be accepted on the first edge after release.

Configuration
REQ-027 Macro URP_PCIE_SER_STATS_EN defined: adds outputs frame_cnt_o [31:0] (frames fully sent, increments on accepted last beat) and drop_cnt_o [15:0] (saturating drop count), both reset to 0.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Widths, beat count and the FSM state enum SHALL live in shared package urp_pcie_pkg.
REQ-030 Frame storage SHALL be sub-module urp_pcie_frame_fifo (synchronous FIFO, push/pop/full/empty, width DATA_WIDTH+CRC_WIDTH).

Verification
REQ-031 One frame, data=224'h1..., checksum=32'hDEADBEEF, ready_i=1 -> 4 consecutive beats, beat3 = {32'hDEADBEEF, data[223:192]}, last_o only on beat3.
REQ-032 Two frames on consecutive cycles, ready_i=1 -> 8 beats, no bubble between beat3 and the next beat0.
REQ-033 ready_i low for 5 cycles during beat1 -> data_o and last_o constant, then beats 2-3 follow.
REQ-034 ready_i=0, 6 consecutive valid_i frames with FIFO_DEPTH=4 -> frames 5 and 6 dropped, overflow_o=1, then 4 frames out intact.
REQ-035 FIFO full, valid_i coincides with an accepted last beat -> frame accepted, overflow_o stays 0.
REQ-036 rst pulse during beat2 -> all outputs 0 immediately; a new frame after release starts at beat0.
